// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives a req/ready instruction-memory handshake, honours the
// decode-stage stall and redirects fetch on decode-resolved branch/jump.
// Optional feature macro: IF_DELAY_SLOT_EN (one architectural delay slot).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | request outstanding at pc; word consumed when it returns
// S_HOLD  | word returned during stall; parked in hold buffer, no request
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        if_valid
);

`ifdef IF_DELAY_SLOT_EN
    localparam bit SLOT = 1'b1;
`else
    localparam bit SLOT = 1'b0;
`endif

    typedef enum logic {S_FETCH, S_HOLD} state_t;

    state_t      state, state_nx;
    logic        run;
    logic [31:0] pc, pc_nx;
    logic [31:0] hold_inst, hold_pc4;
    logic        load_hold;
    logic        kill, kill_nx;
    logic        pend, pend_nx;
    logic [31:0] pend_tgt, pend_tgt_nx;
    logic [31:0] pc4_nx, inst_nx;
    logic        valid_nx;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic        squash;
    logic [31:0] word;
    logic [31:0] word_pc4;

    // Redirect qualification and datapath selects.
    always_comb begin
        redir     = if_valid & ~stall & ((pcsource == 2'b01) | (pcsource == 2'b10));
        redir_tgt = (pcsource == 2'b01) ? bpc : jpc;
        pc_plus4  = pc + 32'd4;
        deliver   = run & ~stall & ((state == S_HOLD) | imem_ready);
        squash    = redir & ~SLOT;
        word      = (state == S_HOLD) ? hold_inst : imem_rdata;
        word_pc4  = (state == S_HOLD) ? hold_pc4 : pc_plus4;
        imem_req  = run & (state == S_FETCH);
        imem_addr = pc;
    end

    // Next-state, next-PC and IF/ID update decisions.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        kill_nx     = kill;
        pend_nx     = pend;
        pend_tgt_nx = pend_tgt;
        pc4_nx      = pc4;
        inst_nx     = inst;
        valid_nx    = if_valid;
        load_hold   = 1'b0;
        if (deliver) begin
            if (kill | squash) begin
                inst_nx  = NOP_INST;
                valid_nx = 1'b0;
            end else begin
                pc4_nx   = word_pc4;
                inst_nx  = word;
                valid_nx = 1'b1;
            end
            pc_nx    = pend ? pend_tgt : (redir ? redir_tgt : pc_plus4);
            kill_nx  = 1'b0;
            pend_nx  = 1'b0;
            state_nx = S_FETCH;
        end else if (run && state == S_FETCH && imem_ready && stall) begin
            load_hold = 1'b1;
            state_nx  = S_HOLD;
        end else if (run && state == S_FETCH && !imem_ready && !stall) begin
            inst_nx  = NOP_INST;
            valid_nx = 1'b0;
            if (redir) begin
                pend_nx     = 1'b1;
                pend_tgt_nx = redir_tgt;
                if (!SLOT) kill_nx = 1'b1;
            end
        end
    end

    // Control state: FSM, PC, kill and redirect-pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            run      <= 1'b0;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            pend     <= 1'b0;
            pend_tgt <= 32'd0;
        end else begin
            state    <= state_nx;
            run      <= 1'b1;
            pc       <= pc_nx;
            kill     <= kill_nx;
            pend     <= pend_nx;
            pend_tgt <= pend_tgt_nx;
        end
    end

    // Hold buffer parks a word that returned while decode was stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_inst <= NOP_INST;
            hold_pc4  <= 32'd0;
        end else if (load_hold) begin
            hold_inst <= imem_rdata;
            hold_pc4  <= pc_plus4;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc4      <= 32'd0;
            inst     <= NOP_INST;
            if_valid <= 1'b0;
        end else begin
            pc4      <= pc4_nx;
            inst     <= inst_nx;
            if_valid <= valid_nx;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed table, corner sequences and a
// randomized run checked against a program-order reference model.
module tb_if_stage;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc4, inst;
    logic        if_valid;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource),
        .bpc(bpc), .jpc(jpc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc4(pc4), .inst(inst), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    // Memory returns its own address with bit 0 set.
    assign imem_rdata = imem_addr | 32'h1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic [1:0] ps,
                        input logic [31:0] b, input logic [31:0] j);
        imem_ready = r; stall = s; pcsource = ps; bpc = b; jpc = j;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; pcsource = 2'b00; bpc = 0; jpc = 0; imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_0x10();
        do_reset();
        repeat (5) tick(1'b1, 1'b0, 2'b00, 0, 0);
        chk("pre_addr", imem_addr, 32'h10);
        chk("pre_inst", inst, 32'h0D);
    endtask

    typedef struct {
        logic        ready;
        logic        stall;
        logic        exp_req;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic        chk_pc4;
        logic [31:0] exp_pc4;
        logic [31:0] exp_inst;
        logic        exp_valid;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic rq, logic ca, logic [31:0] a,
                                logic cp, logic [31:0] p, logic [31:0] i, logic v);
        vec_t x;
        x.ready = r; x.stall = s; x.exp_req = rq; x.chk_addr = ca; x.exp_addr = a;
        x.chk_pc4 = cp; x.exp_pc4 = p; x.exp_inst = i; x.exp_valid = v;
        return x;
    endfunction

    vec_t vt[13];

    logic [31:0] exp_pc, slot_tgt, tgt, b, j, p_addr, p_pc4, p_inst;
    logic        slot_pend, p_req, p_ready, p_stall, p_valid, r, s;
    logic [1:0]  ps;
    int          n_deliv;

    initial begin
        // Free-run, three not-ready cycles at 8, then a 2-cycle stall with word ready.
        vt[0]  = mk(1, 0, 0, 1, 32'd0,  1, 32'd0,  32'd0,  0);
        vt[1]  = mk(1, 0, 1, 1, 32'd0,  1, 32'd0,  32'd0,  0);
        vt[2]  = mk(1, 0, 1, 1, 32'd4,  1, 32'd4,  32'd1,  1);
        vt[3]  = mk(0, 0, 1, 1, 32'd8,  1, 32'd8,  32'd5,  1);
        vt[4]  = mk(0, 0, 1, 1, 32'd8,  0, 32'd0,  32'd0,  0);
        vt[5]  = mk(0, 0, 1, 1, 32'd8,  0, 32'd0,  32'd0,  0);
        vt[6]  = mk(1, 0, 1, 1, 32'd8,  0, 32'd0,  32'd0,  0);
        vt[7]  = mk(1, 1, 1, 1, 32'd12, 1, 32'd12, 32'd9,  1);
        vt[8]  = mk(1, 1, 0, 0, 32'd0,  1, 32'd12, 32'd9,  1);
        vt[9]  = mk(0, 0, 0, 0, 32'd0,  1, 32'd12, 32'd9,  1);
        vt[10] = mk(1, 0, 1, 1, 32'd16, 1, 32'd16, 32'd13, 1);
        vt[11] = mk(1, 0, 1, 1, 32'd20, 1, 32'd20, 32'd17, 1);
        vt[12] = mk(1, 0, 1, 1, 32'd24, 1, 32'd24, 32'd21, 1);

        do_reset();
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("tbl%0d_req", k), imem_req, vt[k].exp_req);
            if (vt[k].chk_addr) chk($sformatf("tbl%0d_addr", k), imem_addr, vt[k].exp_addr);
            if (vt[k].chk_pc4) chk($sformatf("tbl%0d_pc4", k), pc4, vt[k].exp_pc4);
            chk($sformatf("tbl%0d_inst", k), inst, vt[k].exp_inst);
            chk($sformatf("tbl%0d_valid", k), if_valid, vt[k].exp_valid);
            tick(vt[k].ready, vt[k].stall, 2'b00, 0, 0);
        end

        // Taken branch to 0x100 while the 0x10 fetch returns in the same cycle.
        run_to_0x10();
        tick(1'b1, 1'b0, 2'b01, 32'h100, 32'h0);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_valid", if_valid, DS);
        chk("br_inst", inst, DS ? 32'h11 : NOP);
        if (DS) chk("br_pc4", pc4, 32'h14);
        tick(1'b1, 1'b0, 2'b00, 0, 0);
        chk("br_tgt_inst", inst, 32'h101);
        chk("br_tgt_pc4", pc4, 32'h104);
        chk("br_tgt_valid", if_valid, 1'b1);

        // Jump to 0x200 while the 0x10 fetch is still outstanding.
        run_to_0x10();
        tick(1'b0, 1'b0, 2'b10, 32'h0, 32'h200);
        chk("jp_addr_w1", imem_addr, 32'h10);
        chk("jp_valid_w1", if_valid, 1'b0);
        tick(1'b0, 1'b0, 2'b00, 0, 0);
        chk("jp_addr_w2", imem_addr, 32'h10);
        tick(1'b1, 1'b0, 2'b00, 0, 0);
        chk("jp_addr", imem_addr, 32'h200);
        chk("jp_ret_valid", if_valid, DS);
        chk("jp_ret_inst", inst, DS ? 32'h11 : NOP);
        tick(1'b1, 1'b0, 2'b00, 0, 0);
        chk("jp_tgt_inst", inst, 32'h201);
        chk("jp_tgt_pc4", pc4, 32'h204);

        // pc+4 wraps modulo 2^32.
        run_to_0x10();
        tick(1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 2'b00, 0, 0);
        chk("wrap_inst", inst, 32'hFFFF_FFFD);
        chk("wrap_pc4", pc4, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Asynchronous reset while parked in S_HOLD.
        do_reset();
        repeat (3) tick(1'b1, 1'b0, 2'b00, 0, 0);
        tick(1'b1, 1'b1, 2'b00, 0, 0);
        chk("hold_req", imem_req, 1'b0);
        #2;
        rst = 1'b1; stall = 1'b0;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_valid", if_valid, 1'b0);
        chk("arst_inst", inst, NOP);
        chk("arst_pc4", pc4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_rel_req", imem_req, 1'b0);
        tick(1'b1, 1'b0, 2'b00, 0, 0);
        chk("arst_first_req", imem_req, 1'b1);
        chk("arst_first_addr", imem_addr, 32'h0);

        // Randomized run against a program-order model: every delivered valid
        // instruction must be the next one on the architectural path.
        do_reset();
        exp_pc = 32'h0; slot_pend = 1'b0; slot_tgt = 0; n_deliv = 0;
        p_req = 1'b0; p_ready = 1'b0; p_stall = 1'b0; p_addr = 0;
        p_pc4 = 0; p_inst = 0; p_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (p_req && !p_ready) chk("rnd_addr_hold", imem_addr, p_addr);
            if (p_stall) begin
                chk("rnd_frz_inst", inst, p_inst);
                chk("rnd_frz_pc4", pc4, p_pc4);
                chk("rnd_frz_valid", if_valid, p_valid);
            end else if (if_valid) begin
                chk("rnd_inst", inst, exp_pc | 32'h1);
                chk("rnd_pc4", pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
                if (slot_pend) begin
                    exp_pc = slot_tgt;
                    slot_pend = 1'b0;
                end
            end else begin
                chk("rnd_bubble", inst, NOP);
            end

            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 2) != 0);
            ps = 2'($urandom_range(0, 7) < 2 ? $urandom_range(1, 3) : 0);
            case ($urandom_range(0, 3))
                0:       tgt = imem_addr;
                1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
                default: tgt = $urandom & 32'hFFFF_FFFC;
            endcase
            b = (ps == 2'b01) ? tgt : ($urandom & 32'hFFFF_FFFC);
            j = (ps == 2'b10) ? tgt : ($urandom & 32'hFFFF_FFFC);
            if (if_valid && !s && (ps == 2'b01 || ps == 2'b10)) begin
                if (DS) begin
                    slot_pend = 1'b1;
                    slot_tgt  = tgt;
                end else begin
                    exp_pc = tgt;
                end
            end

            p_req = imem_req; p_ready = r; p_stall = s; p_addr = imem_addr;
            p_pc4 = pc4; p_inst = inst; p_valid = if_valid;
            tick(r, s, ps, b, j);
        end
        chk("rnd_deliveries_enough", 32'(n_deliv >= 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
